// File: rtl/pvr_interp_pkg.sv
// Shared types and constants for the interpolator sequencer.
// Holds the state encoding, the latched primitive record and a lowest-set-bit helper.
package pvr_interp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_SETTLE = 3'd3,
      ST_EMIT   = 3'd4
   } sched_state_e;

   localparam int TILE_ROWS = 32;
   localparam int ATTR_MAX  = 8;
   localparam int ROW_W     = 1024;
   localparam int VEC_W     = 144;
   localparam int ATTR_W    = 3;
   localparam int ROW_IDX_W = 5;
   localparam int TILE_W    = 6;
   localparam int PS_W      = 11;
   localparam int SETTLE_W  = 4;

   localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(TILE_ROWS - 1);

   typedef struct packed {
      logic [TILE_W-1:0]   tile_x;
      logic [TILE_W-1:0]   tile_y;
      logic [ATTR_MAX-1:0] mask;
      logic [7:0]          frac_bits;
      logic [VEC_W-1:0]    fx;
      logic [VEC_W-1:0]    fy;
   } interp_sched_prim_t;

   function automatic logic [ATTR_W-1:0] lowest_set(input logic [ATTR_MAX-1:0] m);
      logic [ATTR_W-1:0] idx;
      idx = {ATTR_W{1'b0}};
      for (int i = ATTR_MAX - 1; i >= 0; i--) begin
         idx = m[i] ? ATTR_W'(i) : idx;
      end
      return idx;
   endfunction

endpackage

// File: rtl/interp_sched_attr_next_sel.sv
// Attribute slot selector: next set bit above the current slot, plus the
// lowest and highest set bits of the mask.
module attr_next_sel
   import pvr_interp_pkg::*;
(
   input  logic [ATTR_MAX-1:0] mask,
   input  logic [ATTR_W-1:0]   cur_idx,
   output logic                found,
   output logic [ATTR_W-1:0]   next_idx,
   output logic [ATTR_W-1:0]   low_idx,
   output logic [ATTR_W-1:0]   high_idx
);

   // Descending scan leaves the smallest qualifying index; ascending leaves the largest.
   always_comb begin
      found    = 1'b0;
      next_idx = {ATTR_W{1'b0}};
      high_idx = {ATTR_W{1'b0}};
      low_idx  = lowest_set(mask);
      for (int i = ATTR_MAX - 1; i >= 0; i--) begin
         found    = found | (mask[i] && (i > int'(cur_idx)));
         next_idx = (mask[i] && (i > int'(cur_idx))) ? ATTR_W'(i) : next_idx;
      end
      for (int i = 0; i < ATTR_MAX; i++) begin
         high_idx = mask[i] ? ATTR_W'(i) : high_idx;
      end
   end

endmodule

// File: rtl/interp_sched.sv
// Sequencer that time-shares one plane-equation interpolator across all enabled
// attributes and all 32 rows of a tile, with a multicycle settle before capture.
module interp_sched
   import pvr_interp_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
)
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 abort,
   input  logic                 prim_valid,
   output logic                 prim_ready,
   input  logic [TILE_W-1:0]    prim_tile_x,
   input  logic [TILE_W-1:0]    prim_tile_y,
   input  logic [ATTR_MAX-1:0]  prim_attr_mask,
   input  logic [7:0]           prim_frac_bits,
   input  logic [VEC_W-1:0]     prim_fx,
   input  logic [VEC_W-1:0]     prim_fy,
   output logic                 attr_rd_en,
   output logic [ATTR_W-1:0]    attr_rd_idx,
   input  logic [VEC_W-1:0]     attr_rd_data,
   output logic [VEC_W-1:0]     ip_fx,
   output logic [VEC_W-1:0]     ip_fy,
   output logic [VEC_W-1:0]     ip_fz,
   output logic [PS_W-1:0]      ip_x_ps,
   output logic [PS_W-1:0]      ip_y_ps,
   output logic [7:0]           ip_frac_bits,
   input  logic [ROW_W-1:0]     ip_row,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ROW_W-1:0]     out_data,
   output logic [ATTR_W-1:0]    out_attr,
   output logic [ROW_IDX_W-1:0] out_row,
   output logic                 out_last,
   output logic                 busy
);

   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

   sched_state_e          state_r;
   interp_sched_prim_t    prim_r;
   logic [ROW_IDX_W-1:0]  row_r;
   logic [ATTR_W-1:0]     attr_r;
   logic [SETTLE_W-1:0]   settle_cnt_r;
   logic                  attr_rd_en_r;
   logic [ATTR_W-1:0]     attr_rd_idx_r;
   logic [VEC_W-1:0]      ip_fx_r;
   logic [VEC_W-1:0]      ip_fy_r;
   logic [VEC_W-1:0]      ip_fz_r;
   logic [PS_W-1:0]       ip_x_ps_r;
   logic [PS_W-1:0]       ip_y_ps_r;
   logic [7:0]            ip_frac_bits_r;
   logic                  out_valid_r;
   logic [ROW_W-1:0]      out_data_r;
   logic [ATTR_W-1:0]     out_attr_r;
   logic [ROW_IDX_W-1:0]  out_row_r;
   logic                  out_last_r;

   logic                  prim_ready_s;
   logic                  found_s;
   logic [ATTR_W-1:0]     next_s;
   logic [ATTR_W-1:0]     low_s;
   logic [ATTR_W-1:0]     high_s;

   attr_next_sel u_attr_next_sel (
      .mask     (prim_r.mask),
      .cur_idx  (attr_r),
      .found    (found_s),
      .next_idx (next_s),
      .low_idx  (low_s),
      .high_idx (high_s)
   );

   assign prim_ready_s = (state_r == ST_IDLE) && !abort && !reset;

   // Sequencer state, interpolator drives and captured row result.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         prim_r         <= '0;
         row_r          <= {ROW_IDX_W{1'b0}};
         attr_r         <= {ATTR_W{1'b0}};
         settle_cnt_r   <= {SETTLE_W{1'b0}};
         attr_rd_en_r   <= 1'b0;
         attr_rd_idx_r  <= {ATTR_W{1'b0}};
         ip_fx_r        <= {VEC_W{1'b0}};
         ip_fy_r        <= {VEC_W{1'b0}};
         ip_fz_r        <= {VEC_W{1'b0}};
         ip_x_ps_r      <= {PS_W{1'b0}};
         ip_y_ps_r      <= {PS_W{1'b0}};
         ip_frac_bits_r <= 8'd0;
         out_valid_r    <= 1'b0;
         out_data_r     <= {ROW_W{1'b0}};
         out_attr_r     <= {ATTR_W{1'b0}};
         out_row_r      <= {ROW_IDX_W{1'b0}};
         out_last_r     <= 1'b0;
      end else if (abort && (state_r != ST_IDLE)) begin
         state_r      <= ST_IDLE;
         out_valid_r  <= 1'b0;
         attr_rd_en_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               attr_rd_en_r <= 1'b0;
               if (prim_valid && prim_ready_s) begin
                  prim_r.tile_x    <= prim_tile_x;
                  prim_r.tile_y    <= prim_tile_y;
                  prim_r.mask      <= prim_attr_mask;
                  prim_r.frac_bits <= prim_frac_bits;
                  prim_r.fx        <= prim_fx;
                  prim_r.fy        <= prim_fy;
                  row_r            <= {ROW_IDX_W{1'b0}};
                  attr_r           <= lowest_set(prim_attr_mask);
                  attr_rd_idx_r    <= lowest_set(prim_attr_mask);
                  if (prim_attr_mask != {ATTR_MAX{1'b0}}) begin
                     state_r      <= ST_FETCH;
                     attr_rd_en_r <= 1'b1;
                  end
               end
            end
            ST_FETCH: begin
               attr_rd_en_r <= 1'b0;
               state_r      <= ST_LOAD;
            end
            ST_LOAD: begin
               ip_fz_r        <= attr_rd_data;
               ip_fx_r        <= prim_r.fx;
               ip_fy_r        <= prim_r.fy;
               ip_x_ps_r      <= {prim_r.tile_x, 5'd0};
               ip_y_ps_r      <= {prim_r.tile_y, row_r};
               ip_frac_bits_r <= prim_r.frac_bits;
               settle_cnt_r   <= {SETTLE_W{1'b0}};
               state_r        <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (settle_cnt_r == SETTLE_LAST) begin
                  out_data_r  <= ip_row;
                  out_attr_r  <= attr_r;
                  out_row_r   <= row_r;
                  out_last_r  <= (row_r == LAST_ROW) && (attr_r == high_s);
                  out_valid_r <= 1'b1;
                  state_r     <= ST_EMIT;
               end else begin
                  settle_cnt_r <= settle_cnt_r + 4'd1;
               end
            end
            ST_EMIT: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  if (found_s) begin
                     attr_r        <= next_s;
                     attr_rd_idx_r <= next_s;
                     attr_rd_en_r  <= 1'b1;
                     state_r       <= ST_FETCH;
                  end else if (row_r == LAST_ROW) begin
                     state_r <= ST_IDLE;
                  end else begin
                     attr_r        <= low_s;
                     attr_rd_idx_r <= low_s;
                     row_r         <= row_r + 5'd1;
                     attr_rd_en_r  <= 1'b1;
                     state_r       <= ST_FETCH;
                  end
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               out_valid_r  <= 1'b0;
               attr_rd_en_r <= 1'b0;
            end
         endcase
      end
   end

   assign prim_ready   = prim_ready_s;
   assign busy         = (state_r != ST_IDLE);
   assign attr_rd_en   = attr_rd_en_r;
   assign attr_rd_idx  = attr_rd_idx_r;
   assign ip_fx        = ip_fx_r;
   assign ip_fy        = ip_fy_r;
   assign ip_fz        = ip_fz_r;
   assign ip_x_ps      = ip_x_ps_r;
   assign ip_y_ps      = ip_y_ps_r;
   assign ip_frac_bits = ip_frac_bits_r;
   assign out_valid    = out_valid_r;
   assign out_data     = out_data_r;
   assign out_attr     = out_attr_r;
   assign out_row      = out_row_r;
   assign out_last     = out_last_r;

endmodule

// File: tb/tb_interp_sched.sv
// Directed bench for interp_sched with a behavioural interpolator and attribute store.
module tb_interp_sched;

   logic            clock = 1'b0;
   logic            reset, abort, prim_valid, prim_ready;
   logic [5:0]      prim_tile_x, prim_tile_y;
   logic [7:0]      prim_attr_mask, prim_frac_bits;
   logic [143:0]    prim_fx, prim_fy, fx_c, fy_c;
   logic            attr_rd_en;
   logic [2:0]      attr_rd_idx;
   logic [143:0]    attr_rd_data = 144'd0;
   logic [143:0]    ip_fx, ip_fy, ip_fz;
   logic [10:0]     ip_x_ps, ip_y_ps;
   logic [7:0]      ip_frac_bits;
   logic [1023:0]   ip_row;
   logic            out_valid, out_ready, out_last, busy;
   logic [1023:0]   out_data;
   logic [2:0]      out_attr;
   logic [4:0]      out_row;

   int n_vec = 0;
   int n_err = 0;

   interp_sched #(.SETTLE_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .abort(abort),
      .prim_valid(prim_valid), .prim_ready(prim_ready),
      .prim_tile_x(prim_tile_x), .prim_tile_y(prim_tile_y),
      .prim_attr_mask(prim_attr_mask), .prim_frac_bits(prim_frac_bits),
      .prim_fx(prim_fx), .prim_fy(prim_fy),
      .attr_rd_en(attr_rd_en), .attr_rd_idx(attr_rd_idx), .attr_rd_data(attr_rd_data),
      .ip_fx(ip_fx), .ip_fy(ip_fy), .ip_fz(ip_fz),
      .ip_x_ps(ip_x_ps), .ip_y_ps(ip_y_ps), .ip_frac_bits(ip_frac_bits),
      .ip_row(ip_row),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_attr(out_attr), .out_row(out_row), .out_last(out_last), .busy(busy)
   );

   always #5 clock = ~clock;

   // Attribute store: data returned the cycle after the read strobe.
   always @(posedge clock) begin
      if (attr_rd_en) attr_rd_data <= {112'd0, 32'hA5A5_0000 + {29'd0, attr_rd_idx}};
   end

   assign ip_row = {32{ip_fz[31:0] ^ {10'd0, ip_y_ps, ip_x_ps} ^ ip_fx[31:0]}};

   function automatic logic [1023:0] exp_row(input logic [2:0] a, input logic [5:0] tx,
                                             input logic [5:0] ty, input logic [4:0] r);
      logic [31:0] w;
      w = (32'hA5A5_0000 + {29'd0, a}) ^ {10'd0, ty, r, tx, 5'd0} ^ 32'h1234_5678;
      return {32{w}};
   endfunction

   task automatic send_prim(input logic [5:0] tx, input logic [5:0] ty, input logic [7:0] m);
      prim_tile_x = tx; prim_tile_y = ty; prim_attr_mask = m;
      prim_frac_bits = 8'h0C; prim_fx = fx_c; prim_fy = fy_c; prim_valid = 1'b1;
      @(negedge clock);
      prim_valid = 1'b0;
   endtask

   task automatic wait_out(output int k);
      k = 0;
      do begin
         @(negedge clock);
         k++;
      end while (out_valid !== 1'b1 && k < 100);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      n_vec++;
      if ({out_valid, out_last, busy, attr_rd_en, prim_ready} !== 5'b0 || out_data !== 1024'd0 ||
          ip_fz !== 144'd0 || ip_y_ps !== 11'd0) begin
         n_err++;
         $display("FAIL reset_state: valid/last/busy/rd/ready=%b want 00000", {out_valid, out_last, busy, attr_rd_en, prim_ready});
      end
      reset = 1'b0;
      #1;
      n_vec++;
      if (prim_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", prim_ready); end
      @(negedge clock);
   endtask

   task automatic test_single_attr;
      int k;
      out_ready = 1'b1;
      send_prim(6'd2, 6'd3, 8'h01);
      n_vec++;
      if (attr_rd_en !== 1'b1 || attr_rd_idx !== 3'd0) begin
         n_err++; $display("FAIL single_fetch: rd_en=%b idx=%0d want 1/0", attr_rd_en, attr_rd_idx);
      end
      for (int r = 0; r < 32; r++) begin
         wait_out(k);
         n_vec++;
         if (k !== ((r == 0) ? 6 : 7)) begin n_err++; $display("FAIL single_spacing row %0d: got %0d want %0d", r, k, (r == 0) ? 6 : 7); end
         n_vec++;
         if (out_attr !== 3'd0 || out_row !== 5'(r) || out_last !== (r == 31)) begin
            n_err++; $display("FAIL single_tag: attr=%0d row=%0d last=%b want 0/%0d/%b", out_attr, out_row, out_last, r, r == 31);
         end
         n_vec++;
         if (ip_x_ps !== 11'd64 || ip_y_ps !== 11'(96 + r)) begin
            n_err++; $display("FAIL single_ps: x=%0d y=%0d want 64/%0d", ip_x_ps, ip_y_ps, 96 + r);
         end
         n_vec++;
         if (out_data !== exp_row(3'd0, 6'd2, 6'd3, 5'(r))) begin
            n_err++; $display("FAIL single_data row %0d: got %h want %h", r, out_data[31:0], exp_row(3'd0, 6'd2, 6'd3, 5'(r)) >> 992);
         end
         if (r == 0) begin
            n_vec++;
            if (ip_fx !== fx_c || ip_fy !== fy_c || ip_frac_bits !== 8'h0C) begin
               n_err++; $display("FAIL single_ipvec: fx=%h frac=%h want %h/0c", ip_fx[31:0], ip_frac_bits, fx_c[31:0]);
            end
         end
      end
      @(negedge clock);
      n_vec++;
      if (prim_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL single_done: ready=%b busy=%b want 1/0", prim_ready, busy); end
   endtask

   task automatic test_multi_attr;
      int k;
      logic [2:0] a;
      logic [2:0] order [3];
      order[0] = 3'd2; order[1] = 3'd5; order[2] = 3'd7;
      out_ready = 1'b1;
      send_prim(6'd0, 6'd1, 8'b1010_0100);
      for (int i = 0; i < 96; i++) begin
         wait_out(k);
         a = order[i % 3];
         n_vec++;
         if (k !== ((i == 0) ? 6 : 7) || out_attr !== a || out_row !== 5'(i / 3) || out_last !== (i == 95)) begin
            n_err++; $display("FAIL multi_seq %0d: k=%0d attr=%0d row=%0d last=%b want attr %0d row %0d", i, k, out_attr, out_row, out_last, a, i / 3);
         end
         n_vec++;
         if (out_data !== exp_row(a, 6'd0, 6'd1, 5'(i / 3))) begin
            n_err++; $display("FAIL multi_data %0d: got %h", i, out_data[31:0]);
         end
      end
      @(negedge clock);
      n_vec++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL multi_done: busy=%b valid=%b want 0/0", busy, out_valid); end
   endtask

   task automatic test_backpressure;
      int k, extra_rd;
      logic stable;
      logic [1023:0] sd;
      logic [2:0] sa;
      logic [4:0] sr;
      out_ready = 1'b1;
      send_prim(6'd1, 6'd1, 8'h03);
      for (int i = 0; i < 64; i++) begin
         wait_out(k);
         n_vec++;
         if (k !== ((i == 0) ? 6 : 7) || out_attr !== 3'(i % 2) || out_row !== 5'(i / 2) ||
             out_data !== exp_row(3'(i % 2), 6'd1, 6'd1, 5'(i / 2))) begin
            n_err++; $display("FAIL bp_seq %0d: k=%0d attr=%0d row=%0d data=%h", i, k, out_attr, out_row, out_data[31:0]);
         end
         if (i == 10) begin
            out_ready = 1'b0;
            sd = out_data; sa = out_attr; sr = out_row;
            stable = 1'b1; extra_rd = 0;
            repeat (20) begin
               @(negedge clock);
               if (out_valid !== 1'b1 || out_data !== sd || out_attr !== sa || out_row !== sr) stable = 1'b0;
               if (attr_rd_en !== 1'b0) extra_rd++;
            end
            out_ready = 1'b1;
            n_vec++;
            if (stable !== 1'b1) begin n_err++; $display("FAIL bp_stable: got %b want 1", stable); end
            n_vec++;
            if (extra_rd != 0) begin n_err++; $display("FAIL bp_no_read: got %0d reads want 0", extra_rd); end
         end
      end
      @(negedge clock);
      n_vec++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL bp_done: busy=%b valid=%b want 0/0", busy, out_valid); end
   endtask

   task automatic test_empty_mask;
      int hits;
      n_vec++;
      if (prim_ready !== 1'b1) begin n_err++; $display("FAIL empty_pre_ready: got %b want 1", prim_ready); end
      send_prim(6'd3, 6'd3, 8'h00);
      n_vec++;
      if (prim_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL empty_ready: ready=%b busy=%b want 1/0", prim_ready, busy); end
      hits = 0;
      repeat (10) begin
         if (attr_rd_en !== 1'b0 || out_valid !== 1'b0) hits++;
         @(negedge clock);
      end
      n_vec++;
      if (hits != 0) begin n_err++; $display("FAIL empty_quiet: got %0d active cycles want 0", hits); end
   endtask

   task automatic test_abort;
      int k, hits;
      out_ready = 1'b1;
      send_prim(6'd0, 6'd2, 8'h01);
      for (int r = 0; r < 10; r++) wait_out(k);
      n_vec++;
      if (out_row !== 5'd9) begin n_err++; $display("FAIL abort_pre_row: got %0d want 9", out_row); end
      repeat (3) @(negedge clock);
      n_vec++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || ip_y_ps !== {6'd2, 5'd10}) begin
         n_err++; $display("FAIL abort_in_settle: busy=%b valid=%b y=%0d want 1/0/74", busy, out_valid, ip_y_ps);
      end
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      #1;
      n_vec++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || prim_ready !== 1'b1) begin
         n_err++; $display("FAIL abort_idle: busy=%b valid=%b ready=%b want 0/0/1", busy, out_valid, prim_ready);
      end
      hits = 0;
      repeat (10) begin
         if (attr_rd_en !== 1'b0 || out_valid !== 1'b0) hits++;
         @(negedge clock);
      end
      n_vec++;
      if (hits != 0) begin n_err++; $display("FAIL abort_quiet: got %0d active cycles want 0", hits); end
      abort = 1'b1;
      prim_attr_mask = 8'h01; prim_valid = 1'b1;
      #1;
      n_vec++;
      if (prim_ready !== 1'b0) begin n_err++; $display("FAIL abort_blocks_ready: got %b want 0", prim_ready); end
      @(negedge clock);
      abort = 1'b0; prim_valid = 1'b0;
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL abort_not_accepted: busy=%b want 0", busy); end
      out_ready = 1'b0;
      send_prim(6'd4, 6'd5, 8'h02);
      wait_out(k);
      n_vec++;
      if (k !== 6 || out_attr !== 3'd1 || out_row !== 5'd0 || ip_y_ps !== 11'd160 || ip_x_ps !== 11'd128 ||
          out_data !== exp_row(3'd1, 6'd4, 6'd5, 5'd0)) begin
         n_err++; $display("FAIL abort_restart: k=%0d attr=%0d row=%0d y=%0d x=%0d", k, out_attr, out_row, ip_y_ps, ip_x_ps);
      end
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL abort_in_emit: valid=%b busy=%b want 0/0", out_valid, busy); end
      out_ready = 1'b1;
   endtask

   task automatic test_reset_in_emit;
      int k;
      out_ready = 1'b0;
      send_prim(6'd7, 6'd9, 8'h80);
      wait_out(k);
      n_vec++;
      if (out_valid !== 1'b1 || out_attr !== 3'd7 || k !== 6) begin
         n_err++; $display("FAIL rst_emit_pre: valid=%b attr=%0d k=%0d want 1/7/6", out_valid, out_attr, k);
      end
      reset = 1'b1;
      #1;
      n_vec++;
      if (prim_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_low: got %b want 0", prim_ready); end
      @(negedge clock);
      n_vec++;
      if ({out_valid, out_last, busy, attr_rd_en} !== 4'b0 || out_attr !== 3'd0 || out_row !== 5'd0 ||
          attr_rd_idx !== 3'd0 || out_data !== 1024'd0 || ip_fx !== 144'd0 || ip_fy !== 144'd0 ||
          ip_fz !== 144'd0 || ip_x_ps !== 11'd0 || ip_y_ps !== 11'd0 || ip_frac_bits !== 8'd0) begin
         n_err++; $display("FAIL rst_outputs: valid=%b attr=%0d x=%0d y=%0d fz=%h want all 0", out_valid, out_attr, ip_x_ps, ip_y_ps, ip_fz[31:0]);
      end
      n_vec++;
      if (prim_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_held: got %b want 0", prim_ready); end
      reset = 1'b0;
      out_ready = 1'b1;
      @(negedge clock);
      n_vec++;
      if (prim_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL rst_release: ready=%b busy=%b want 1/0", prim_ready, busy); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; abort = 1'b0; prim_valid = 1'b0; out_ready = 1'b0;
      prim_tile_x = 6'd0; prim_tile_y = 6'd0; prim_attr_mask = 8'd0; prim_frac_bits = 8'd0;
      fx_c = {48'h0000_0000_0001, 48'h0000_0000_0002, 48'h0000_1234_5678};
      fy_c = {48'h0000_0000_0003, 48'h0000_0000_0004, 48'h0000_0BAD_F00D};
      prim_fx = 144'd0; prim_fy = 144'd0;
      @(negedge clock);
      test_reset;
      test_single_attr;
      test_multi_attr;
      test_backpressure;
      test_empty_mask;
      test_abort;
      test_reset_in_emit;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
